// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier and its control-unit peer.
// The control unit reuses MULT_ITER and CNT_W for its wait-state timeout.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_ITER = 32;
  localparam int CNT_W     = 6;

endpackage

// File: rtl/mult_booth_if.sv
// start/finished handshake between the control unit and the multiplier,
// plus the operand and product buses.
interface mult_booth_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             finished;

  modport master (
    output start, a, b,
    input  hi, lo, busy, finished
  );

  modport slave (
    input  start, a, b,
    output hi, lo, busy, finished
  );
endinterface

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: add/sub M on {Q0,q-1}, then an
// arithmetic right shift of {Acc, Q, q-1}.
import mult_pkg::*;

module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] q_n,
  output logic             q_m1_n
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    unique case ({q[0], q_m1})
      2'b10:   sum = acc - m;
      2'b01:   sum = acc + m;
      default: sum = acc;
    endcase
    // q-1 falls off the bottom; Acc's sign bit is replicated at the top
    {acc_n, q_n, q_m1_n} = {sum[WIDTH], sum, q};
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed multiplier, radix-2 Booth, one iteration per cycle.
// Responder side of the start/finished handshake; drives HI/LO.
import mult_pkg::*;

module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mult_booth_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   m;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             finished;

  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] q_n;
  logic             q_m1_n;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .q      (q),
    .q_m1   (q_m1),
    .m      (m),
    .acc_n  (acc_n),
    .q_n    (q_n),
    .q_m1_n (q_m1_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      m        <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            m     <= {bus.a[WIDTH-1], bus.a};
            acc   <= '0;
            q     <= bus.b;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= q_m1_n;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            hi       <= acc_n[WIDTH-1:0];
            lo       <= q_n;
            finished <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          finished <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.busy     = busy;
  assign bus.finished = finished;

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed corner cases plus random
// operands against a plain signed-multiply reference.
import mult_pkg::*;

module tb_mult_booth;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mult_booth_if #(.WIDTH(32)) bus ();

  mult_booth #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    longint px;
    longint py;
    px = longint'($signed(x));
    py = longint'($signed(y));
    return 64'(px * py);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for finished; returns cycles after E0.
  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     output int lat);
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_e0", 64'(bus.busy), 64'd1);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.finished) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] x,
                           input logic [31:0] y);
    int lat;
    run(x, y, lat);
    check({tag, "_lat"}, 64'(lat), 64'(MULT_ITER));
    check({tag, "_prod"}, {bus.hi, bus.lo}, ref_mul(x, y));
    @(negedge clk);
    check({tag, "_fin_fall"}, 64'(bus.finished), 64'd0);
    check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] held;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("rst_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_fin", 64'(bus.finished), 64'd0);
    rst_n = 1'b1;

    run(32'd3, 32'd5, lat);
    check("basic_lat", 64'(lat), 64'd32);
    check("basic_prod", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
    @(negedge clk);
    check("basic_busy_low", 64'(bus.busy), 64'd0);
    check("basic_fin_low", 64'(bus.finished), 64'd0);

    run_check("neg1x1", 32'hFFFF_FFFF, 32'd1);
    check("neg1x1_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_check("m7xm6", -32'sd7, -32'sd6);
    check("m7xm6_const", {bus.hi, bus.lo}, 64'd42);
    run_check("minxmin", 32'h8000_0000, 32'h8000_0000);
    check("minxmin_const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    run_check("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000);
    check("maxxmin_const", {bus.hi, bus.lo}, 64'hC000_0000_8000_0000);

    for (int k = 0; k < 8; k++) begin
      x = $urandom;
      y = $urandom;
      run_check($sformatf("rand%0d", k), x, y);
    end

    // Requests while busy: at E10 and during DONE, both ignored
    @(negedge clk);
    bus.a = 32'd1234;
    bus.b = 32'd5678;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    lat = -1;
    for (int i = 1; i <= 80; i++) begin
      if (i == 10) begin
        bus.a = 32'd99;
        bus.b = 32'd77;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.finished) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          check("ign_prod", {bus.hi, bus.lo}, 64'd7006652);
          bus.a = 32'd11;
          bus.b = 32'd13;
          bus.start = 1'b1;
          @(negedge clk);
          i++;
        end
      end
    end
    bus.start = 1'b0;
    check("ign_lat", 64'(lat), 64'd32);
    check("ign_pulses", 64'(pulses), 64'd1);
    check("ign_prod_hold", {bus.hi, bus.lo}, 64'd7006652);
    check("ign_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset abort mid-run
    @(negedge clk);
    bus.a = 32'd100;
    bus.b = 32'd200;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_fin", 64'(bus.finished), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.finished || bus.busy) pulses++;
    end
    check("abort_no_activity", 64'(pulses), 64'd0);
    run_check("after_abort", 32'd6, 32'd7);
    check("after_abort_lo", 64'(bus.lo), 64'd42);

    // Back-to-back with start held high
    @(negedge clk);
    bus.a = 32'd2;
    bus.b = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 32'd4;
    bus.b = 32'd5;
    pulses = 0;
    held = '0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 32) begin
        check("b2b_fin1", 64'(bus.finished), 64'd1);
        check("b2b_lo1", {bus.hi, bus.lo}, 64'd6);
        held = {bus.hi, bus.lo};
      end
      if (i > 32 && i < 66 && {bus.hi, bus.lo} !== held)
        pulses++;
      if (i == 66) begin
        check("b2b_fin2", 64'(bus.finished), 64'd1);
        check("b2b_lo2", {bus.hi, bus.lo}, 64'd20);
        bus.start = 1'b0;
      end
    end
    check("b2b_stable", 64'(pulses), 64'd0);
    check("b2b_idle", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_booth.md
# mult_booth

Sequential signed 32×32 multiplier using radix-2 Booth. It is the responder side of the `start`/`finished` handshake that the control unit already drives for `div`. It drives the `msb_mult`/`lsb_mult` inputs of the HI/LO muxes and so serves MULT alongside the divider. Operands are captured on `start` and the 64-bit product is returned after a fixed 32-iteration run.

## Interface
- `WIDTH`, default 32: operand width. Product width is 2×`WIDTH`.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: reset, asynchronous, active-low.
- `start` input, 1: request from the control unit. Sampled only in IDLE.
- `a` input, `WIDTH`: multiplicand, signed, from register A.
- `b` input, `WIDTH`: multiplier, signed, from register B.
- `hi` output, `WIDTH`: product[63:32]. Feeds the `msb_mult` net.
- `lo` output, `WIDTH`: product[31:0]. Feeds the `lsb_mult` net.
- `busy` output, 1: high whenever the state is not IDLE.
- `finished` output, 1: one-cycle pulse marking that `hi`/`lo` hold a new product.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1.
  - RUN→DONE after the 32nd iteration.
  - DONE→IDLE unconditionally.
- **Capture (IDLE with `start`=1):**
  - M ← sign-extend(`a`) to 33 bits.
  - Acc ← 0 (33 bits).
  - Q ← `b`.
  - q₋₁ ← 0.
  - count ← 0.
- **RUN iteration, one per cycle:**
  - Examine {Q[0], q₋₁}:
    - 10: Acc ← Acc − M.
    - 01: Acc ← Acc + M.
    - 00 or 11: no change.
  - Then arithmetic-right-shift the 66-bit {Acc, Q, q₋₁} by one.
  - count ← count + 1.
  - All arithmetic is 33-bit two's complement. The extra bit makes `a` = −2³¹ exact; no overflow is possible or flagged.
- **Product:** after 32 iterations the product is {Acc[31:0], Q}. On the RUN→DONE edge, `hi` ← Acc[31:0] and `lo` ← Q.
- **Output hold:** `hi`/`lo` change only on the RUN→DONE edge and on reset. Between operations they hold the last product.
- **`finished`:** asserted only in DONE, i.e. exactly one cycle per accepted `start`.
- **`start` outside IDLE** (RUN or DONE) is ignored; it is neither queued nor restarts the operation. Operand changes on `a`/`b` after capture have no effect.
- **Reset mid-operation:** aborts immediately. State → IDLE, `hi`=`lo`=0, `busy`=0, `finished`=0, and all internal registers cleared.
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `finished`=0, state IDLE.

## Timing
- Edge E0 samples `start`=1 in IDLE. `busy` is high from just after E0.
- RUN occupies the cycles between E0 and E32. Iterations are performed at edges E1…E32.
- At E32 `hi`/`lo` are loaded, DONE is entered and `finished` rises. At E33 `finished` falls and `busy` falls.
- Latency, start-sampling edge to `finished`: 32 cycles. Issue interval: 34 cycles.
- Back-to-back: `start` held high through DONE is ignored there and sampled again at E34, the first IDLE edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mult_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - `MULT_ITER` = 32.
  - count width = 6 bits.
- The package is reusable by the control unit for its wait-state timeout check.
- Optional combinational sub-module `booth_step`: inputs {Acc, Q, q₋₁, M}, output the next {Acc, Q, q₋₁}. Instantiated once, which isolates the add/sub/shift datapath for unit test.
- No other sub-modules.

## Test plan
- **Basic:** `a`=3, `b`=5, pulse `start` → `finished` one cycle at E32, `hi`=0x00000000, `lo`=0x0000000F, `busy` low after E33.
- **Signs:** `a`=0xFFFFFFFF (−1), `b`=1 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFF; `a`=−7, `b`=−6 → `hi`=0, `lo`=42.
- **Extremes:** `a`=`b`=0x80000000 → `hi`=0x40000000, `lo`=0x00000000; `a`=0x7FFFFFFF, `b`=0x80000000 → `hi`=0xC0000000, `lo`=0x80000000.
- **Busy-ignore:** re-pulse `start` with new operands at E10 and during DONE → the original product is unchanged, exactly one `finished` pulse, and the second request is not run.
- **Reset abort:** drop `reset` low at E15 → `hi`=`lo`=0, `busy`=0 immediately (asynchronous), no `finished`. After release, a new `start` with 6×7 gives `lo`=42 at +32 cycles.
- **Back-to-back:** hold `start` high continuously with 2×3 then 4×5 → `finished` at E32 (`lo`=6) and at E66 (`lo`=20), and `hi`/`lo` stable in between.
